// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// The state encoding is visible on the state output.
package pc_seq_pkg;

  localparam int              PC_W              = 16;
  localparam logic [PC_W-1:0] PC_INC            = 16'd2;
  localparam logic [PC_W-1:0] RESET_VEC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push while full overwrites the oldest entry.
// A pop while empty is ignored; only the pointer and count are reset.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp;
  logic [CW-1:0] count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // sp points at the next free slot; wrap-around relies on DEPTH being a power of two.
  assign top   = mem[sp - PW'(1)];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp <= sp + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      sp    <= sp - PW'(1);
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[sp] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: INIT/RUN/HALTED FSM choosing the next PC by fixed
// priority, with a return-address stack for call/return.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VEC = RESET_VEC_DEFAULT,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  input  logic            branch_en,
  input  logic [PC_W-1:0] jb_offset,
  input  logic            jump_en,
  input  logic            call_en,
  input  logic            ret_en,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc_out,
  output logic            pc_valid,
  output logic [1:0]      state,
  output logic            ras_ovf,
  output logic            ras_unf
);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_seq, pc_br;
  logic            ovf_q, unf_q;
  logic            set_ovf, set_unf;
  logic            push, pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_full, ras_empty;

  assign pc_seq = pc_q + PC_INC;
  assign pc_br  = pc_q + jb_offset;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      pc_q    <= RESET_VEC;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    unique case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN: begin
        if (stall) begin
          // everything holds
        end else if (halt) begin
          state_d = ST_HALTED;
        end else if (ret_en) begin
          // ret outranks call, so a simultaneous call never pushes
          if (ras_empty) begin
            pc_d    = pc_seq;
            set_unf = 1'b1;
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
          end
        end else if (call_en) begin
          push    = 1'b1;
          set_ovf = ras_full;
          pc_d    = jump_target;
        end else if (jump_en) begin
          pc_d = jump_target;
        end else if (branch_en) begin
          pc_d = pc_br;
        end else begin
          pc_d = pc_seq;
        end
      end
      ST_HALTED: if (resume) state_d = ST_RUN;
      default:   state_d = ST_INIT;
    endcase
  end

  assign pc_out   = pc_q;
  assign pc_valid = (state_q == ST_RUN);
  assign state    = state_q;
  assign ras_ovf  = ovf_q;
  assign ras_unf  = unf_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 16'h0000, PC value loaded at reset.
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 stall  input  1  hold PC and RAS this cycle.
REQ-006 halt  input  1  request entry to HALTED.
REQ-007 resume  input  1  leave HALTED.
REQ-008 branch_en  input  1  branch taken; target = PC + jb_offset.
REQ-009 jb_offset  input  16  branch offset, two's complement.
REQ-010 jump_en  input  1  absolute jump to jump_target.
REQ-011 call_en  input  1  push PC+2, jump to jump_target.
REQ-012 ret_en  input  1  pop RAS into PC.
REQ-013 jump_target  input  16  absolute target for jump/call.
REQ-014 pc_out  output  16  current PC, registered.
REQ-015 pc_valid  output  1  high when pc_out is a fetchable address (state RUN).
REQ-016 state  output  2  FSM state encoding: 0 INIT, 1 RUN, 2 HALTED.
REQ-017 ras_ovf  output  1  sticky: push while RAS full.
REQ-018 ras_unf  output  1  sticky: pop while RAS empty.

Function
REQ-019 FSM SHALL have states INIT, RUN, HALTED; INIT SHALL last exactly one cycle after reset deassertion, then go to RUN unconditionally.
REQ-020 In INIT, pc_out SHALL equal RESET_VEC and pc_valid SHALL be 0; all control inputs SHALL be ignored.
REQ-021 In RUN, next PC SHALL be chosen by fixed priority: stall > halt > ret_en > call_en > jump_en > branch_en > sequential.
REQ-022 stall: PC, RAS, state, and flags SHALL hold.
REQ-023 halt (no stall): state SHALL go to HALTED next cycle, PC SHALL hold, pc_valid SHALL drop in the same cycle as the state change.
REQ-024 Sequential: PC <= PC + 2, modulo 2^16 (16'hFFFE -> 16'h0000).
REQ-025 Branch: PC <= (PC + jb_offset) mod 2^16, no carry out, no alignment forcing (16'hFFFE + 16'hFFFF = 16'hFFFD).
REQ-026 Jump: PC <= jump_target.
REQ-027 Call: push (PC + 2) mod 2^16, PC <= jump_target; if RAS full, oldest entry SHALL be overwritten (circular), depth stays RAS_DEPTH, ras_ovf set.
REQ-028 Ret: if RAS non-empty, PC <= top entry, pop; if empty, PC <= PC + 2, RAS unchanged, ras_unf set.
REQ-029 Simultaneous call_en and ret_en SHALL perform only the return (no push).
REQ-030 In HALTED, PC and RAS SHALL hold, pc_valid = 0; stall, halt, branch, jump, call, ret SHALL be ignored; resume SHALL return to RUN next cycle with PC unchanged.
REQ-031 halt and resume both high in HALTED: resume wins.
REQ-032 Latency: any RUN-state decision SHALL appear on pc_out exactly one clock after the sampling edge.

Reset
REQ-033 rst_n low at a rising edge SHALL, regardless of state or in-flight stall/halt: PC <= RESET_VEC, state <= INIT, RAS emptied (count 0), ras_ovf <= 0, ras_unf <= 0, pc_valid <= 0.
REQ-034 Reset SHALL take priority over every other input.
REQ-035 RAS storage contents need not be cleared; only pointer/count SHALL reset.

Structure
REQ-036 Package pc_seq_pkg SHALL hold the state enum, PC_W = 16, PC_INC = 16'd2, and the default RESET_VEC.
REQ-037 RAS SHALL be a sub-module ras_stack (push, pop, top, full, empty, circular overwrite on full push), parameterised by RAS_DEPTH and PC_W.
REQ-038 Next-PC add SHALL be a plain 16-bit modulo adder; no dependency on any external adder module.

Verification
REQ-039 Reset release, no controls: pc_out 0000 (INIT, valid 0), then 0000 valid 1, then 0002, 0004.
REQ-040 PC=16'hFFFE, branch_en, jb_offset=16'hFFFF -> next pc_out 16'hFFFD; PC=16'hFFFE sequential -> 16'h0000.
REQ-041 PC=16'h0010, call_en target 16'h0100 -> pc 0100; then ret_en -> pc 0012; ret_en again -> pc 0014, ras_unf=1.
REQ-042 Five calls with RAS_DEPTH=4 from PCs 0x10,0x20,0x30,0x40,0x50 (targets 0x20..0x60) -> ras_ovf=1; four returns yield 0x52,0x42,0x32,0x22; fifth sets ras_unf.
REQ-043 halt at PC 0x0040 with stall=0 -> HALTED, pc_valid 0, pc 0x0040 held over 5 cycles despite jump_en; resume -> RUN, pc 0x0040, then 0x0042.
REQ-044 rst_n low during HALTED with ras_ovf=1 and stall=1 -> next edge: pc RESET_VEC, state INIT, flags 0, RAS empty.
